ctrl_pipeline_v2: RTL and testbench
===================================

Name: ctrl_pipeline_v2

Overview:
- Parametrised successor to the pipelined controller's register chain (ID/EX, EX/MEM, MEM/WB).
- Takes decoded control from the decoder in ID and carries it through EX, a configurable number of MEM stages, and WB.
- Resolves branches in EX for all six RV32I branch types.
- Adds three behaviours the previous controller lacked: EX stall, multi-cycle MUL/DIV occupancy with a busy request, and deeper memory pipelines.

Parameters:
- MEM_STAGES, 1: number of MEM pipeline registers between EX and WB; legal range 1..3.
- MULDIV_LAT, 4: cycles a MUL/DIV op occupies EX; legal range 1..32; 1 means single-cycle.
- ALUCTL_W, 4: ALU control width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- RegWriteD, MemWriteD, JumpD, JalrD, BranchD, ALUSrcAD, MulDivD  in  1 each  decoded controls
- ALUSrcBD  in  2  ALU B-operand select
- ResultSrcD  in  2  writeback select
- ALUControlD  in  ALUCTL_W  ALU op
- funct3D  in  3  branch type
- StallE  in  1  hold the EX register (from the hazard unit)
- FlushE  in  1  bubble the EX register
- ZeroE, LtE, LtuE  in  1 each  ALU flags: equal, signed less-than, unsigned less-than
- RegWriteE, MemWriteE, ALUSrcAE  out  1  EX controls
- ALUSrcBE  out  2  EX B-operand select
- ALUControlE  out  ALUCTL_W  EX ALU op
- ResultSrcE0  out  1  bit 0 of ResultSrcE (load-use detect)
- PCSrcE  out  1  redirect PC
- PCJalSrcE  out  1  JALR target select
- BusyE  out  1  EX occupied by MUL/DIV; hazard unit must stall F/D
- RegWriteM, MemWriteM  out  1  first MEM stage controls
- RegWriteW  out  1  WB register write
- ResultSrcW  out  2  WB result select

Behaviour:
- Reset (synchronous, highest priority):
  - All stage registers and the latency counter clear to 0.
  - All outputs are 0 in the cycle after the reset edge.
- EX register update, priority order:
  - reset, then FlushE, then hold (StallE | BusyE), then load from D.
  - Flush clears every control bit, including MulDiv and Jalr.
- Latency counter cnt, width clog2(MULDIV_LAT+1):
  - On an edge that loads EX with MulDivD=1 and MULDIV_LAT>1: cnt <= MULDIV_LAT-1.
  - While cnt!=0: cnt decrements by 1 each edge.
  - BusyE = (cnt != 0), combinational from cnt.
  - Result: a MUL/DIV op is present in EX for exactly MULDIV_LAT cycles.
  - FlushE clears cnt to 0 on the same edge (aborts the op).
  - StallE while cnt!=0 does not pause the countdown.
- EX to M1 transfer (RegWrite, MemWrite, ResultSrc):
  - When EX is held, or FlushE=1 on that edge, M1 loads a bubble (RegWrite=0, MemWrite=0, ResultSrc=0).
  - Otherwise M1 takes the EX contents.
  - M2..M[MEM_STAGES] shift unconditionally; W takes the last M stage.
  - RegWriteM and MemWriteM come from M1.
- Latency: a non-muldiv instruction present in EX at cycle t appears in M1 at t+1 and in W at t+1+MEM_STAGES.
- Branch resolution:
  - Taken condition by funct3E:
    - 000: ZeroE
    - 001: !ZeroE
    - 100: LtE
    - 101: !LtE
    - 110: LtuE
    - 111: !LtuE
    - 010/011: never taken
  - PCSrcE = JumpE | (BranchE & taken), combinational.
  - PCSrcE is forced to 0 while BusyE=1.
- PCJalSrcE = JalrE.
- Simultaneous events:
  - FlushE together with StallE: flush wins.
  - FlushE during BusyE: the op is dropped, BusyE=0 the next cycle, and no bubble beyond the flushed slot.
- Reset mid-MUL/DIV: the counter and every stage clear; no write-back of the aborted op.

Test Plan:
- Basic pass-through: MEM_STAGES=1; issue an ADD (RegWriteD=1, ResultSrcD=00) → RegWriteE=1 at t+1, RegWriteM=1 at t+2, RegWriteW=1 at t+3; then 0 after a following bubble.
- Branch matrix: BNE (funct3D=001) with ZeroE=0 → PCSrcE=1; BGEU (111) with LtuE=1 → 0; BLT (100) with LtE=1 → 1; funct3D=010 → 0 for all flag combinations.
- MUL/DIV occupancy: MULDIV_LAT=4; issue MulDivD=1, RegWriteD=1 → BusyE=1 for 3 cycles; the EX outputs stay constant for 4 cycles; RegWriteM stays 0 during busy; RegWriteM=1 exactly once afterwards.
- Flush during busy: FlushE=1 on the 2nd busy cycle → next cycle BusyE=0 and RegWriteE=0; RegWriteW never asserts for that op.
- Depth: MEM_STAGES=3; an ADD in EX at cycle 10 → RegWriteW=1 at cycle 14 only; StallE=1 for 2 cycles inserts 2 bubbles in M1 (RegWriteM=0).
- Reset: assert reset mid-busy with non-zero values in every stage → all outputs 0 the next cycle; BusyE=0; the pipeline resumes cleanly after release.

Source files
------------

// File: rtl/ctrl_pipeline_v2.sv
// rtl/ctrl_pipeline_v2.sv - ID/EX, EX/MEM[1..N], MEM/WB control register chain
// Holds EX for stalls and multi-cycle MUL/DIV, resolves branches in EX.
module ctrl_pipeline_v2 #(
  parameter int MEM_STAGES = 1,
  parameter int MULDIV_LAT = 4,
  parameter int ALUCTL_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                RegWriteD,
  input  logic                MemWriteD,
  input  logic                JumpD,
  input  logic                JalrD,
  input  logic                BranchD,
  input  logic                ALUSrcAD,
  input  logic                MulDivD,
  input  logic [1:0]          ALUSrcBD,
  input  logic [1:0]          ResultSrcD,
  input  logic [ALUCTL_W-1:0] ALUControlD,
  input  logic [2:0]          funct3D,
  input  logic                StallE,
  input  logic                FlushE,
  input  logic                ZeroE,
  input  logic                LtE,
  input  logic                LtuE,
  output logic                RegWriteE,
  output logic                MemWriteE,
  output logic                ALUSrcAE,
  output logic [1:0]          ALUSrcBE,
  output logic [ALUCTL_W-1:0] ALUControlE,
  output logic                ResultSrcE0,
  output logic                PCSrcE,
  output logic                PCJalSrcE,
  output logic                BusyE,
  output logic                RegWriteM,
  output logic                MemWriteM,
  output logic                RegWriteW,
  output logic [1:0]          ResultSrcW
);
  localparam int CNT_W = $clog2(MULDIV_LAT + 1);

  logic                reg_write_e, mem_write_e, jump_e, jalr_e, branch_e, alu_src_a_e;
  logic [1:0]          alu_src_b_e, result_src_e;
  logic [ALUCTL_W-1:0] alu_control_e;
  logic [2:0]          funct3_e;
  logic [CNT_W-1:0]    cnt;
  logic                busy, hold, advance, taken;

  logic                m_reg_write  [MEM_STAGES];
  logic [1:0]          m_result_src [MEM_STAGES];
  logic                m1_mem_write;
  logic                w_reg_write;
  logic [1:0]          w_result_src;

  assign busy    = (cnt != '0);
  assign hold    = StallE | busy;
  assign advance = !hold && !FlushE;

  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      reg_write_e   <= 1'b0;
      mem_write_e   <= 1'b0;
      jump_e        <= 1'b0;
      jalr_e        <= 1'b0;
      branch_e      <= 1'b0;
      alu_src_a_e   <= 1'b0;
      alu_src_b_e   <= '0;
      result_src_e  <= '0;
      alu_control_e <= '0;
      funct3_e      <= '0;
    end else if (!hold) begin
      reg_write_e   <= RegWriteD;
      mem_write_e   <= MemWriteD;
      jump_e        <= JumpD;
      jalr_e        <= JalrD;
      branch_e      <= BranchD;
      alu_src_a_e   <= ALUSrcAD;
      alu_src_b_e   <= ALUSrcBD;
      result_src_e  <= ResultSrcD;
      alu_control_e <= ALUControlD;
      funct3_e      <= funct3D;
    end
  end

  // The countdown runs through stalls; a new op only loads when EX is free.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      cnt <= '0;
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
    end else if (!StallE && MulDivD && (MULDIV_LAT > 1)) begin
      cnt <= CNT_W'(MULDIV_LAT - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_STAGES; i++) begin
        m_reg_write[i]  <= 1'b0;
        m_result_src[i] <= '0;
      end
      m1_mem_write <= 1'b0;
      w_reg_write  <= 1'b0;
      w_result_src <= '0;
    end else begin
      m_reg_write[0]  <= advance & reg_write_e;
      m_result_src[0] <= advance ? result_src_e : 2'b00;
      m1_mem_write    <= advance & mem_write_e;
      for (int i = 1; i < MEM_STAGES; i++) begin
        m_reg_write[i]  <= m_reg_write[i-1];
        m_result_src[i] <= m_result_src[i-1];
      end
      w_reg_write  <= m_reg_write[MEM_STAGES-1];
      w_result_src <= m_result_src[MEM_STAGES-1];
    end
  end

  always_comb begin
    taken = 1'b0;
    case (funct3_e)
      3'b000:  taken = ZeroE;
      3'b001:  taken = !ZeroE;
      3'b100:  taken = LtE;
      3'b101:  taken = !LtE;
      3'b110:  taken = LtuE;
      3'b111:  taken = !LtuE;
      default: taken = 1'b0;
    endcase
  end

  assign RegWriteE   = reg_write_e;
  assign MemWriteE   = mem_write_e;
  assign ALUSrcAE    = alu_src_a_e;
  assign ALUSrcBE    = alu_src_b_e;
  assign ALUControlE = alu_control_e;
  assign ResultSrcE0 = result_src_e[0];
  assign PCSrcE      = (jump_e | (branch_e & taken)) & !busy;
  assign PCJalSrcE   = jalr_e;
  assign BusyE       = busy;
  assign RegWriteM   = m_reg_write[0];
  assign MemWriteM   = m1_mem_write;
  assign RegWriteW   = w_reg_write;
  assign ResultSrcW  = w_result_src;
endmodule

// File: tb/tb_ctrl_pipeline_v2.sv
// tb/tb_ctrl_pipeline_v2.sv - randomized and directed bench for ctrl_pipeline_v2
// Two instances (1 and 3 MEM stages) share stimulus and one history-based model.
module tb_ctrl_pipeline_v2;
  localparam int LAT = 4;

  typedef struct packed {
    logic rw, mw; logic [1:0] rs; logic jump, jalr, branch, asa;
    logic [1:0] asb; logic [3:0] aluc; logic [2:0] f3; logic md;
  } ctl_t;
  typedef struct packed { logic rw, mw; logic [1:0] rs; } mem_t;

  logic clk = 1'b0;
  logic reset, stall, flush, zero, lt, ltu;
  ctl_t d;
  int n_checks = 0, n_fail = 0;

  ctl_t ex_m;
  int   age;
  mem_t hist [0:3];

  logic [17:0] obs_a, obs_b;
  logic rwe_a, mwe_a, asa_a, rs0_a, pcs_a, jal_a, busy_a, rwm_a, mwm_a, rww_a;
  logic rwe_b, mwe_b, asa_b, rs0_b, pcs_b, jal_b, busy_b, rwm_b, mwm_b, rww_b;
  logic [1:0] asb_a, rsw_a, asb_b, rsw_b;
  logic [3:0] aluc_a, aluc_b;

  always #5 clk = ~clk;

  ctrl_pipeline_v2 #(.MEM_STAGES(1), .MULDIV_LAT(LAT), .ALUCTL_W(4)) dut_a (
    .clk(clk), .reset(reset), .RegWriteD(d.rw), .MemWriteD(d.mw), .JumpD(d.jump),
    .JalrD(d.jalr), .BranchD(d.branch), .ALUSrcAD(d.asa), .MulDivD(d.md),
    .ALUSrcBD(d.asb), .ResultSrcD(d.rs), .ALUControlD(d.aluc), .funct3D(d.f3),
    .StallE(stall), .FlushE(flush), .ZeroE(zero), .LtE(lt), .LtuE(ltu),
    .RegWriteE(rwe_a), .MemWriteE(mwe_a), .ALUSrcAE(asa_a), .ALUSrcBE(asb_a),
    .ALUControlE(aluc_a), .ResultSrcE0(rs0_a), .PCSrcE(pcs_a), .PCJalSrcE(jal_a),
    .BusyE(busy_a), .RegWriteM(rwm_a), .MemWriteM(mwm_a), .RegWriteW(rww_a),
    .ResultSrcW(rsw_a));

  ctrl_pipeline_v2 #(.MEM_STAGES(3), .MULDIV_LAT(LAT), .ALUCTL_W(4)) dut_b (
    .clk(clk), .reset(reset), .RegWriteD(d.rw), .MemWriteD(d.mw), .JumpD(d.jump),
    .JalrD(d.jalr), .BranchD(d.branch), .ALUSrcAD(d.asa), .MulDivD(d.md),
    .ALUSrcBD(d.asb), .ResultSrcD(d.rs), .ALUControlD(d.aluc), .funct3D(d.f3),
    .StallE(stall), .FlushE(flush), .ZeroE(zero), .LtE(lt), .LtuE(ltu),
    .RegWriteE(rwe_b), .MemWriteE(mwe_b), .ALUSrcAE(asa_b), .ALUSrcBE(asb_b),
    .ALUControlE(aluc_b), .ResultSrcE0(rs0_b), .PCSrcE(pcs_b), .PCJalSrcE(jal_b),
    .BusyE(busy_b), .RegWriteM(rwm_b), .MemWriteM(mwm_b), .RegWriteW(rww_b),
    .ResultSrcW(rsw_b));

  assign obs_a = {rwe_a, mwe_a, asa_a, asb_a, aluc_a, rs0_a, pcs_a, jal_a, busy_a,
                  rwm_a, mwm_a, rww_a, rsw_a};
  assign obs_b = {rwe_b, mwe_b, asa_b, asb_b, aluc_b, rs0_b, pcs_b, jal_b, busy_b,
                  rwm_b, mwm_b, rww_b, rsw_b};

  // An op is busy for its first LAT-1 cycles in EX.
  function automatic logic m_busy();
    return ex_m.md && (age < LAT - 1);
  endfunction

  function automatic logic m_taken(input logic [2:0] f3);
    case (f3)
      3'b000:  return zero;
      3'b001:  return !zero;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [17:0] exp_vec(input int s);
    logic pcsrc;
    pcsrc = !m_busy() && (ex_m.jump || (ex_m.branch && m_taken(ex_m.f3)));
    return {ex_m.rw, ex_m.mw, ex_m.asa, ex_m.asb, ex_m.aluc, ex_m.rs[0], pcsrc,
            ex_m.jalr, m_busy(), hist[0].rw, hist[0].mw, hist[s].rw, hist[s].rs};
  endfunction

  task automatic step();
    ctl_t nex;
    int   nage;
    mem_t nm1;
    logic hold_m;
    hold_m = stall || m_busy();
    nm1 = '0;
    if (reset || flush) begin
      nex = '0; nage = 0;
    end else if (hold_m) begin
      nex = ex_m; nage = age + 1;
    end else begin
      nex = d; nage = 0;
      nm1.rw = ex_m.rw; nm1.mw = ex_m.mw; nm1.rs = ex_m.rs;
    end
    @(posedge clk);
    #1;
    if (reset) begin
      for (int k = 0; k < 4; k++) hist[k] = '0;
    end else begin
      for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = nm1;
    end
    ex_m = nex;
    age  = nage;
  endtask

  task automatic idle(input int n);
    d = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic ctl_t add_op();
    ctl_t c;
    c = '0; c.rw = 1'b1;
    return c;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    d = ctl_t'($urandom);
    step(); step();
    n_checks++; if (obs_a !== '0) begin n_fail++; $display("FAIL reset_a: got %h want 0", obs_a); end
    n_checks++; if (obs_b !== '0) begin n_fail++; $display("FAIL reset_b: got %h want 0", obs_b); end
    reset = 1'b0;
    idle(1);
    n_checks++; if (obs_a !== '0) begin n_fail++; $display("FAIL post_reset_a: got %h want 0", obs_a); end
  endtask

  task automatic test_passthrough();
    d = add_op();
    step();
    d = '0;
    n_checks++; if (rwe_a !== 1'b1) begin n_fail++; $display("FAIL pass_rwe: got %b want 1", rwe_a); end
    step();
    n_checks++; if ({rwe_a, rwm_a} !== 2'b01) begin n_fail++; $display("FAIL pass_rwm: got %b want 01", {rwe_a, rwm_a}); end
    step();
    n_checks++; if ({rwm_a, rww_a} !== 2'b01) begin n_fail++; $display("FAIL pass_rww: got %b want 01", {rwm_a, rww_a}); end
    step();
    n_checks++; if (rww_a !== 1'b0) begin n_fail++; $display("FAIL pass_bubble: got %b want 0", rww_a); end
    d = add_op(); d.rs = 2'b01;
    step();
    d = '0;
    n_checks++; if (rs0_a !== 1'b1) begin n_fail++; $display("FAIL load_rs0: got %b want 1", rs0_a); end
    step(); step();
    n_checks++; if ({rww_a, rsw_a} !== 3'b101) begin n_fail++; $display("FAIL load_rsw: got %b want 101", {rww_a, rsw_a}); end
    idle(4);
  endtask

  task automatic test_branch_matrix();
    logic [2:0] f3s [7]  = '{3'b001, 3'b111, 3'b100, 3'b000, 3'b101, 3'b110, 3'b011};
    logic [2:0] flg [7]  = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b000, 3'b001, 3'b111};
    logic       want [7] = '{1'b1,   1'b0,   1'b1,   1'b1,   1'b1,   1'b1,   1'b0};
    for (int i = 0; i < 7; i++) begin
      d = '0; d.branch = 1'b1; d.f3 = f3s[i];
      step();
      {zero, lt, ltu} = flg[i];
      #1;
      n_checks++; if (pcs_a !== want[i]) begin n_fail++; $display("FAIL branch_f3_%b: got %b want %b", f3s[i], pcs_a, want[i]); end
    end
    d = '0; d.branch = 1'b1; d.f3 = 3'b010;
    step();
    for (int f = 0; f < 8; f++) begin
      {zero, lt, ltu} = 3'(f);
      #1;
      n_checks++; if (pcs_a !== 1'b0) begin n_fail++; $display("FAIL branch_010_flags%0d: got %b want 0", f, pcs_a); end
    end
    d = '0; d.jump = 1'b1; d.jalr = 1'b1;
    step();
    n_checks++; if ({pcs_a, jal_a} !== 2'b11) begin n_fail++; $display("FAIL jalr: got %b want 11", {pcs_a, jal_a}); end
    {zero, lt, ltu} = 3'b000;
    idle(4);
  endtask

  task automatic test_muldiv();
    int ones = 0;
    d = add_op(); d.md = 1'b1; d.jump = 1'b1; d.aluc = 4'hA;
    step();
    d = '0;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if ({busy_a, rwe_a, aluc_a, pcs_a, rwm_a} !== {c < 3, 1'b1, 4'hA, c == 3, 1'b0}) begin
        n_fail++;
        $display("FAIL muldiv_cyc%0d: got %b want %b", c, {busy_a, rwe_a, aluc_a, pcs_a, rwm_a},
                 {c < 3, 1'b1, 4'hA, c == 3, 1'b0});
      end
      step();
    end
    for (int c = 0; c < 4; c++) begin
      ones += int'(rwm_a);
      step();
    end
    n_checks++; if (ones != 1) begin n_fail++; $display("FAIL muldiv_rwm_once: got %0d want 1", ones); end
    idle(4);
  endtask

  task automatic test_flush_busy();
    d = add_op(); d.md = 1'b1;
    step();
    d = '0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_checks++; if ({busy_a, rwe_a} !== 2'b00) begin n_fail++; $display("FAIL flush_busy: got %b want 00", {busy_a, rwe_a}); end
    for (int c = 0; c < 6; c++) begin
      n_checks++;
      if ({rwm_a, rww_a, rww_b} !== 3'b000) begin
        n_fail++; $display("FAIL flush_no_wb_%0d: got %b want 000", c, {rwm_a, rww_a, rww_b});
      end
      step();
    end
    idle(2);
  endtask

  task automatic test_depth();
    d = add_op();
    step();
    d = '0;
    for (int k = 1; k <= 6; k++) begin
      step();
      n_checks++; if (rww_b !== (k == 4)) begin n_fail++; $display("FAIL depth_w_%0d: got %b want %b", k, rww_b, k == 4); end
    end
    d = add_op();
    step();
    d = '0; stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++; if ({rwe_b, rwm_b} !== 2'b10) begin n_fail++; $display("FAIL stall_bubble_%0d: got %b want 10", k, {rwe_b, rwm_b}); end
    end
    stall = 1'b0;
    step();
    n_checks++; if ({rwe_b, rwm_b} !== 2'b01) begin n_fail++; $display("FAIL stall_release: got %b want 01", {rwe_b, rwm_b}); end
    idle(5);
  endtask

  task automatic test_reset_midbusy();
    d = add_op(); d.mw = 1'b1; d.rs = 2'b01;
    step();
    d = add_op();
    step();
    d = add_op(); d.md = 1'b1;
    step();
    d = '0;
    n_checks++; if ({busy_a, rwm_a} !== 2'b11) begin n_fail++; $display("FAIL prefill: got %b want 11", {busy_a, rwm_a}); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if ({obs_a, obs_b} !== '0) begin n_fail++; $display("FAIL reset_mid: got %h %h want 0", obs_a, obs_b); end
    for (int c = 0; c < 6; c++) begin
      step();
      n_checks++; if ({rww_a, rww_b} !== 2'b00) begin n_fail++; $display("FAIL reset_no_wb_%0d: got %b want 00", c, {rww_a, rww_b}); end
    end
    d = add_op();
    step();
    d = '0;
    n_checks++; if (rwe_a !== 1'b1) begin n_fail++; $display("FAIL resume_e: got %b want 1", rwe_a); end
    step(); step();
    n_checks++; if (rww_a !== 1'b1) begin n_fail++; $display("FAIL resume_w: got %b want 1", rww_a); end
    idle(4);
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      d     = ctl_t'($urandom);
      d.md  = ($urandom_range(3) == 0);
      stall = ($urandom_range(7) == 0);
      flush = ($urandom_range(11) == 0);
      reset = ($urandom_range(59) == 0);
      {zero, lt, ltu} = 3'($urandom);
      step();
      n_checks++; if (obs_a !== exp_vec(1)) begin n_fail++; $display("FAIL rand_a_%0d: got %h want %h", i, obs_a, exp_vec(1)); end
      n_checks++; if (obs_b !== exp_vec(3)) begin n_fail++; $display("FAIL rand_b_%0d: got %h want %h", i, obs_b, exp_vec(3)); end
    end
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    idle(6);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    d = '0; ex_m = '0; age = 0;
    for (int k = 0; k < 4; k++) hist[k] = '0;
    test_reset();
    test_passthrough();
    test_branch_matrix();
    test_muldiv();
    test_flush_busy();
    test_depth();
    test_reset_midbusy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
